dest_drain: RTL and testbench

DEST_DRAIN -- requirements
Module: dest_drain

---
 rtl/dest_drain.sv | 155 +++++++++++++++
 tb/tb_dest_drain.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_drain.sv
`default_nettype none
// ============================================================================
// Module   : dest_drain
// Purpose  : Round-robin drain of two destination FIFOs, with per-source and
//            per-class saturating counters and sticky route/FIFO error halt.
// Revision : 1.0
// ============================================================================
module dest_drain #(
  parameter int BW = 6,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  input  logic            D0_empty,
  input  logic            D1_empty,
  input  logic            D0_error_output,
  input  logic            D1_error_output,
  input  logic [BW-1:0]   D0_data_out,
  input  logic [BW-1:0]   D1_data_out,
  output logic            D0_rd,
  output logic            D1_rd,
  output logic            out_valid,
  output logic [BW-1:0]   out_data,
  output logic            out_src,
  output logic [CW-1:0]   cnt_d0,
  output logic [CW-1:0]   cnt_d1,
  output logic [4*CW-1:0] cnt_class,
  output logic            route_err,
  output logic            fifo_err,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_CNT_MAX = '1;
  localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next_state;
  logic          r_rr;
  logic          r_valid;
  logic          r_src;
  logic          r_route_err;
  logic          r_fifo_err;
  logic [CW-1:0] r_cnt_d0;
  logic [CW-1:0] r_cnt_d1;
  logic [CW-1:0] r_cnt_cls [4];

  logic          w_d0_ok;
  logic          w_d1_ok;
  logic          w_rd_en;
  logic          w_pick_d1;
  logic          w_d0_rd;
  logic          w_d1_rd;
  logic [BW-1:0] w_data;
  logic [1:0]    w_class;
  logic          w_route_set;
  logic          w_fifo_set;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == C_CNT_MAX) ? v : v + C_CNT_ONE;
  endfunction

  // Reads are also gated by enable/clear so nothing new launches in the
  // cycle the FSM is about to leave READ.
  assign w_d0_ok   = !D0_empty && !D0_error_output;
  assign w_d1_ok   = !D1_empty && !D1_error_output;
  assign w_rd_en   = (r_state == ST_READ) && enable && !clear;
  assign w_pick_d1 = w_d1_ok && (!w_d0_ok || r_rr);
  assign w_d0_rd   = w_rd_en && w_d0_ok && !w_pick_d1;
  assign w_d1_rd   = w_rd_en && w_pick_d1;

  // FIFO read data arrives one cycle after the pop, alongside r_valid.
  assign w_data      = r_src ? D1_data_out : D0_data_out;
  assign w_class     = w_data[BW-1:BW-2];
  assign w_route_set = r_valid && (w_data[BW-2] != r_src);
  assign w_fifo_set  = D0_error_output || D1_error_output;

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else if (w_route_set || w_fifo_set || r_route_err || r_fifo_err) begin
      w_next_state = ST_HALT;
    end else begin
      case (r_state)
        ST_IDLE: if (enable) w_next_state = ST_READ;
        ST_READ: if (!enable) w_next_state = ST_IDLE;
        ST_HALT: w_next_state = ST_HALT;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr        <= 1'b0;
      r_valid     <= 1'b0;
      r_src       <= 1'b0;
      r_route_err <= 1'b0;
      r_fifo_err  <= 1'b0;
      r_cnt_d0    <= '0;
      r_cnt_d1    <= '0;
      for (int k = 0; k < 4; k++) r_cnt_cls[k] <= '0;
    end else begin
      r_valid <= w_d0_rd || w_d1_rd;
      if (w_d0_rd || w_d1_rd) r_src <= w_d1_rd;
      if (clear) begin
        r_rr        <= 1'b0;
        r_route_err <= 1'b0;
        r_fifo_err  <= 1'b0;
        r_cnt_d0    <= '0;
        r_cnt_d1    <= '0;
        for (int k = 0; k < 4; k++) r_cnt_cls[k] <= '0;
      end else begin
        if (w_d0_rd || w_d1_rd) r_rr <= w_d0_rd;
        if (r_valid) begin
          if (r_src) r_cnt_d1 <= sat_inc(r_cnt_d1);
          else       r_cnt_d0 <= sat_inc(r_cnt_d0);
          r_cnt_cls[w_class] <= sat_inc(r_cnt_cls[w_class]);
        end
        if (w_route_set) r_route_err <= 1'b1;
        if (w_fifo_set)  r_fifo_err  <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_cls
    assign cnt_class[k*CW +: CW] = r_cnt_cls[k];
  end

  assign D0_rd     = w_d0_rd;
  assign D1_rd     = w_d1_rd;
  assign out_valid = r_valid;
  assign out_data  = r_valid ? w_data : '0;
  assign out_src   = r_src;
  assign cnt_d0    = r_cnt_d0;
  assign cnt_d1    = r_cnt_d1;
  assign route_err = r_route_err;
  assign fifo_err  = r_fifo_err;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dest_drain.sv
`default_nettype none
// tb_dest_drain: dest_drain (BW=6, CW=3) against two FIFO models, a read-order
// log and an output scoreboard; table of drain cases plus corner sequences.
module tb_dest_drain;
  localparam int BW = 6;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            clear = 1'b0;
  logic            D0_empty, D1_empty;
  logic            D0_error_output = 1'b0;
  logic            D1_error_output = 1'b0;
  logic [BW-1:0]   D0_data_out = '0;
  logic [BW-1:0]   D1_data_out = '0;
  logic            D0_rd, D1_rd, out_valid, out_src, route_err, fifo_err;
  logic [BW-1:0]   out_data;
  logic [CW-1:0]   cnt_d0, cnt_d1;
  logic [4*CW-1:0] cnt_class;
  logic [1:0]      state;

  always #5 clk = ~clk;

  dest_drain #(.BW(BW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .D0_rd(D0_rd), .D1_rd(D1_rd),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .cnt_class(cnt_class),
    .route_err(route_err), .fifo_err(fifo_err), .state(state)
  );

  // FIFO models: registered read data, expected word queued on every pop
  logic [BW-1:0] m0 [256];
  logic [BW-1:0] m1 [256];
  int            h0 = 0, t0 = 0, h1 = 0, t1 = 0, n_rd = 0;
  logic [15:0]   rd_log = '0;
  logic [6:0]    sb [$];

  assign D0_empty = (h0 == t0);
  assign D1_empty = (h1 == t1);

  always @(posedge clk) begin
    if (D0_rd) begin
      D0_data_out <= m0[h0[7:0]];
      sb.push_back({1'b0, m0[h0[7:0]]});
      rd_log <= {rd_log[14:0], 1'b0};
      h0 <= h0 + 1;
      n_rd <= n_rd + 1;
    end
    if (D1_rd) begin
      D1_data_out <= m1[h1[7:0]];
      sb.push_back({1'b1, m1[h1[7:0]]});
      rd_log <= {rd_log[14:0], 1'b1};
      h1 <= h1 + 1;
      n_rd <= n_rd + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [6:0] e;
    @(negedge clk);
    chk("out_valid", out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_data", out_data, e[5:0]);
      chk("out_src", out_src, e[6]);
    end
    chk("rd_onehot", D0_rd & D1_rd, 0);
    if (state == 2'd2) chk("rd_in_halt", D0_rd | D1_rd, 0);
  endtask

  task automatic push0(input logic [BW-1:0] v);
    m0[t0[7:0]] = v;
    t0 = t0 + 1;
  endtask

  task automatic push1(input logic [BW-1:0] v);
    m1[t1[7:0]] = v;
    t1 = t1 + 1;
  endtask

  task automatic do_clear();
    enable = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    t0 = h0;
    t1 = h1;
    chk("clr_cnt_d0", cnt_d0, 0);
    chk("clr_cnt_d1", cnt_d1, 0);
    chk("clr_cnt_class", cnt_class, 0);
    chk("clr_route_err", route_err, 0);
    chk("clr_fifo_err", fifo_err, 0);
    chk("clr_state", state, 0);
  endtask

  typedef struct packed {
    logic [2:0]  n0;
    logic [23:0] d0;
    logic [2:0]  n1;
    logic [23:0] d1;
    logic [3:0]  e_nrd;
    logic [7:0]  e_order;
    logic [2:0]  e_d0;
    logic [2:0]  e_d1;
    logic [11:0] e_cls;
    logic        e_rerr;
    logic [1:0]  e_state;
  } vec_t;

  vec_t        tbl [4];
  vec_t        v;
  logic [23:0] w;
  logic [15:0] msk;
  int          base;
  logic        seen;

  initial begin
    tbl[0] = '{n0: 3'd2, d0: {12'b0, 6'b00_1100, 6'b00_0001}, n1: 3'd0, d1: 24'b0,
               e_nrd: 4'd2, e_order: 8'b00, e_d0: 3'd2, e_d1: 3'd0,
               e_cls: 12'h002, e_rerr: 1'b0, e_state: 2'd1};
    tbl[1] = '{n0: 3'd1, d0: {18'b0, 6'b00_0011}, n1: 3'd2, d1: {12'b0, 6'b01_0111, 6'b01_0100},
               e_nrd: 4'd3, e_order: 8'b011, e_d0: 3'd1, e_d1: 3'd2,
               e_cls: 12'h011, e_rerr: 1'b0, e_state: 2'd1};
    tbl[2] = '{n0: 3'd3, d0: {6'b0, 6'b00_0010, 6'b00_0001, 6'b01_0110}, n1: 3'd0, d1: 24'b0,
               e_nrd: 4'd2, e_order: 8'b00, e_d0: 3'd2, e_d1: 3'd0,
               e_cls: 12'h009, e_rerr: 1'b1, e_state: 2'd2};
    tbl[3] = '{n0: 3'd3, d0: {6'b0, 6'b00_0000, 6'b10_0010, 6'b10_0000}, n1: 3'd2,
               d1: {12'b0, 6'b11_0101, 6'b11_0001},
               e_nrd: 4'd5, e_order: 8'b01010, e_d0: 3'd3, e_d1: 3'd2,
               e_cls: 12'h481, e_rerr: 1'b0, e_state: 2'd1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_cnt_class", cnt_class, 0);
    chk("rst_errs", {route_err, fifo_err}, 0);
    chk("rst_state", state, 0);
    chk("rst_rd", {D0_rd, D1_rd}, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      v = tbl[i];
      do_clear();
      base = n_rd;
      w = v.d0;
      for (int k = 0; k < int'(v.n0); k++) push0(w[k*6 +: 6]);
      w = v.d1;
      for (int k = 0; k < int'(v.n1); k++) push1(w[k*6 +: 6]);
      enable = 1'b1;
      repeat (10) tick();
      msk = (16'd1 << v.e_nrd) - 16'd1;
      chk("tbl_nrd", n_rd - base, v.e_nrd);
      chk("tbl_order", rd_log & msk, v.e_order);
      chk("tbl_cnt_d0", cnt_d0, v.e_d0);
      chk("tbl_cnt_d1", cnt_d1, v.e_d1);
      chk("tbl_cnt_class", cnt_class, v.e_cls);
      chk("tbl_route_err", route_err, v.e_rerr);
      chk("tbl_state", state, v.e_state);
      enable = 1'b0;
      repeat (2) tick();
    end

    // FIFO error pulse while reading
    do_clear();
    for (int k = 0; k < 5; k++) push0(6'(k));
    push1(6'b01_0001);
    push1(6'b01_0010);
    enable = 1'b1;
    repeat (2) tick();
    D1_error_output = 1'b1;
    #1 chk("rd_to_err_fifo", D1_rd, 0);
    tick();
    D1_error_output = 1'b0;
    tick();
    chk("ferr_set", fifo_err, 1);
    chk("ferr_state", state, 2);
    base = n_rd;
    repeat (4) tick();
    chk("ferr_no_rd", n_rd - base, 0);
    do_clear();

    // Saturation with an enable drop mid-stream
    for (int k = 0; k < 9; k++) push1({2'b11, 4'(k)});
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    #1 chk("rd_after_enable_low", D1_rd, 0);
    repeat (3) tick();
    enable = 1'b1;
    repeat (14) tick();
    chk("sat_cnt_d1", cnt_d1, 7);
    chk("sat_cnt_class3", cnt_class[11:9], 7);
    chk("sat_cnt_d0", cnt_d0, 0);

    // Reset one cycle after a D0 pop
    do_clear();
    push0(6'b00_0101);
    push0(6'b00_0110);
    push0(6'b00_0111);
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (D0_rd) seen = 1'b1;
    end
    chk("rd_seen", seen, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    enable = 1'b0;
    sb.delete();
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out_data", out_data, 0);
    chk("rstmid_cnt_d0", cnt_d0, 0);
    chk("rstmid_state", state, 0);
    chk("rstmid_rd", {D0_rd, D1_rd}, 0);
    base = n_rd;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_no_rd", n_rd - base, 0);
    enable = 1'b1;
    #1 chk("first_rd_delay", D0_rd, 0);
    repeat (8) tick();
    chk("resume_cnt_d0", cnt_d0, 2);
    chk("resume_nrd", n_rd - base, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
